// File: rtl/agu_multi.sv
// Multi-channel address generator: each channel walks base + k*stride and wraps to base
// after len steps (len 0 = free-running). All channels load and step independently.
module agu_multi #(
    parameter int NCH = 4,
    parameter int AW  = 16,
    parameter int SW  = 8
) (
    input  logic              sys_clk,
    input  logic              clear_agu,
    input  logic [NCH-1:0]    ld_init,
    input  logic [NCH-1:0]    step,
    input  logic [NCH*AW-1:0] cfg_base,
    input  logic [NCH*SW-1:0] cfg_stride,
    input  logic [NCH*AW-1:0] cfg_len,
    input  logic [NCH-1:0]    cfg_word_mode,
    output logic [NCH*AW-1:0] addr_o,
    output logic [NCH-1:0]    last_o,
    output logic [NCH-1:0]    wrap_o
);

    // Strobes are plain per-cycle enables with no handshake: every ld_init/step
    // pulse sampled high at a rising edge is acted on; there is never a stall.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [AW-1:0] base_q;
        logic [AW-1:0] stride_q;
        logic [AW-1:0] len_q;
        logic [AW-1:0] idx_q;
        logic [AW-1:0] addr_q;
        logic          wrap_q;

        logic [AW-1:0] raw_base;
        logic [AW-1:0] raw_stride;
        logic [AW-1:0] eff_base;
        logic [AW-1:0] eff_stride;
        logic          at_end;

        assign raw_base   = cfg_base[c*AW +: AW];
        assign raw_stride = AW'(cfg_stride[c*SW +: SW]);
        // Word mode drops the top two bits rather than widening the address.
        assign eff_base   = cfg_word_mode[c] ? {raw_base[AW-3:0], 2'b00} : raw_base;
        assign eff_stride = cfg_word_mode[c] ? {raw_stride[AW-3:0], 2'b00} : raw_stride;

        assign at_end = (len_q != '0) && (idx_q == len_q - AW'(1));

        always_ff @(posedge sys_clk) begin
            if (clear_agu) begin
                base_q   <= '0;
                stride_q <= '0;
                len_q    <= '0;
                idx_q    <= '0;
                addr_q   <= '0;
                wrap_q   <= 1'b0;
            end else if (ld_init[c]) begin
                base_q   <= eff_base;
                stride_q <= eff_stride;
                len_q    <= cfg_len[c*AW +: AW];
                idx_q    <= '0;
                addr_q   <= eff_base;
                wrap_q   <= 1'b0;
            end else if (step[c]) begin
                if (at_end) begin
                    addr_q <= base_q;
                    idx_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + stride_q;
                    idx_q  <= idx_q + AW'(1);
                    wrap_q <= 1'b0;
                end
            end else begin
                wrap_q <= 1'b0;
            end
        end

        assign addr_o[c*AW +: AW] = addr_q;
        assign last_o[c]          = at_end;
        assign wrap_o[c]          = wrap_q;
    end

endmodule

// File: tb/tb_agu_multi.sv
// Bench for agu_multi: directed vectors push expected per-channel outputs into a queue;
// a negedge monitor pops and compares them against addr_o/last_o/wrap_o.
module tb_agu_multi;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int SW  = 8;
    localparam int W   = 2 + AW + 2;

    logic              sys_clk = 1'b0;
    logic              clear_agu;
    logic [NCH-1:0]    ld_init;
    logic [NCH-1:0]    step;
    logic [NCH*AW-1:0] cfg_base;
    logic [NCH*SW-1:0] cfg_stride;
    logic [NCH*AW-1:0] cfg_len;
    logic [NCH-1:0]    cfg_word_mode;
    logic [NCH*AW-1:0] addr_o;
    logic [NCH-1:0]    last_o;
    logic [NCH-1:0]    wrap_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    agu_multi #(.NCH(NCH), .AW(AW), .SW(SW)) dut (
        .sys_clk       (sys_clk),
        .clear_agu     (clear_agu),
        .ld_init       (ld_init),
        .step          (step),
        .cfg_base      (cfg_base),
        .cfg_stride    (cfg_stride),
        .cfg_len       (cfg_len),
        .cfg_word_mode (cfg_word_mode),
        .addr_o        (addr_o),
        .last_o        (last_o),
        .wrap_o        (wrap_o)
    );

    // Clock / watchdog
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge sys_clk);
        #1;
        clear_agu = 1'b0;
        ld_init   = '0;
        step      = '0;
    endtask

    task automatic load(input int ch, input logic [AW-1:0] base, input logic [SW-1:0] stride,
                        input logic [AW-1:0] len, input logic wm);
        cfg_base[ch*AW +: AW]   = base;
        cfg_stride[ch*SW +: SW] = stride;
        cfg_len[ch*AW +: AW]    = len;
        cfg_word_mode[ch]       = wm;
        ld_init[ch]             = 1'b1;
    endtask

    task automatic expect_ch(input int ch, input logic [AW-1:0] addr, input logic last,
                             input logic wrap);
        exp_q.push_back({2'(ch), addr, last, wrap});
    endtask

    // Scoreboard monitor
    always @(negedge sys_clk) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            int ch;
            logic [AW-1:0] ea;
            logic el, ew;
            e  = exp_q.pop_front();
            ch = int'(e[W-1 -: 2]);
            ea = e[AW+1:2];
            el = e[1];
            ew = e[0];
            checks++;
            if (addr_o[ch*AW +: AW] !== ea) begin
                errors++;
                $display("FAIL addr ch%0d t=%0t got %h want %h", ch, $time, addr_o[ch*AW +: AW], ea);
            end
            checks++;
            if (last_o[ch] !== el) begin
                errors++;
                $display("FAIL last ch%0d t=%0t got %b want %b", ch, $time, last_o[ch], el);
            end
            checks++;
            if (wrap_o[ch] !== ew) begin
                errors++;
                $display("FAIL wrap ch%0d t=%0t got %b want %b", ch, $time, wrap_o[ch], ew);
            end
        end
    end

    initial begin
        clear_agu     = 1'b1;
        ld_init       = '0;
        step          = '0;
        cfg_base      = '0;
        cfg_stride    = '0;
        cfg_len       = '0;
        cfg_word_mode = '0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Reset with random strobes active
        clear_agu = 1'b1;
        ld_init   = 4'($urandom_range(1, 15));
        step      = 4'($urandom_range(1, 15));
        cfg_base  = {4{16'h1234}};
        cfg_stride = {4{8'h11}};
        tick();
        for (int c = 0; c < NCH; c++) expect_ch(c, 16'h0000, 1'b0, 1'b0);

        // Byte mode ch0: 0x100 stride 3 len 4
        load(0, 16'h0100, 8'd3, 16'd4, 1'b0);
        tick(); expect_ch(0, 16'h0100, 1'b0, 1'b0);
        cfg_base[0 +: AW] = 16'h7777;   // must be ignored without ld_init
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0103, 1'b0, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0106, 1'b0, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0109, 1'b1, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0100, 1'b0, 1'b1);
        tick();                 expect_ch(0, 16'h0100, 1'b0, 1'b0);

        // Word mode ch1: base 0x4001 -> 0x0004, stride 1 -> 4, free-running
        load(1, 16'h4001, 8'd1, 16'd0, 1'b1);
        tick(); expect_ch(1, 16'h0004, 1'b0, 1'b0);
        step[1] = 1'b1; tick(); expect_ch(1, 16'h0008, 1'b0, 1'b0);
        step[1] = 1'b1; tick(); expect_ch(1, 16'h000C, 1'b0, 1'b0);

        // Free-run overflow ch2
        load(2, 16'hFFFE, 8'd2, 16'd0, 1'b0);
        tick(); expect_ch(2, 16'hFFFE, 1'b0, 1'b0);
        step[2] = 1'b1; tick(); expect_ch(2, 16'h0000, 1'b0, 1'b0);
        step[2] = 1'b1; tick(); expect_ch(2, 16'h0002, 1'b0, 1'b0);

        // Collision on ch3 while ch0 steps independently
        load(3, 16'h0050, 8'd5, 16'd3, 1'b0);
        step[3] = 1'b1;
        step[0] = 1'b1;
        tick();
        expect_ch(3, 16'h0050, 1'b0, 1'b0);
        expect_ch(0, 16'h0103, 1'b0, 1'b0);
        step[3] = 1'b1; tick(); expect_ch(3, 16'h0055, 1'b0, 1'b0);
        step[3] = 1'b1; tick(); expect_ch(3, 16'h005A, 1'b1, 1'b0);
        step[3] = 1'b1; tick(); expect_ch(3, 16'h0050, 1'b0, 1'b1);
        // Step during the wrap cycle advances normally
        step[3] = 1'b1; tick(); expect_ch(3, 16'h0055, 1'b0, 1'b0);

        // len = 1 on ch1: last held high, every step wraps
        load(1, 16'h0020, 8'd4, 16'd1, 1'b0);
        tick(); expect_ch(1, 16'h0020, 1'b1, 1'b0);
        step[1] = 1'b1; tick(); expect_ch(1, 16'h0020, 1'b1, 1'b1);
        step[1] = 1'b1; tick(); expect_ch(1, 16'h0020, 1'b1, 1'b1);
        tick();                 expect_ch(1, 16'h0020, 1'b1, 1'b0);

        // Reset mid-sequence on ch0
        load(0, 16'h0100, 8'd3, 16'd4, 1'b0);
        tick(); expect_ch(0, 16'h0100, 1'b0, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0103, 1'b0, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0106, 1'b0, 1'b0);
        clear_agu = 1'b1;
        step[0]   = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++) expect_ch(c, 16'h0000, 1'b0, 1'b0);
        step[0] = 1'b1; tick(); expect_ch(0, 16'h0000, 1'b0, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
